// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle for apb_mem_slave: requester drives the select/enable/address
// group, the completer answers with read data, ready and error.
interface apb_mem_slave_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic [ADDR_W-1:0]     paddr_i;
    logic                  pwrite_i;
    logic [DATA_W-1:0]     pwdata_i;
    logic [DATA_W/8-1:0]   pstrb_i;
    logic [DATA_W-1:0]     prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 completer over a word-addressed array with byte strobes and wait states.
// Define APB_MEM_SLAVE_RANDOM_WAIT_EN for LFSR-driven wait states capped at WAIT_CYCLES.
module apb_mem_slave #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    apb_mem_slave_if.slave   bus
);
    localparam int          BYTES   = DATA_W / 8;
    localparam int          OFF_W   = $clog2(BYTES);
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [3:0]  WAIT_4  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    state_t            phase;
    logic [3:0]        cnt;
    logic [3:0]        load_val;
    logic [ADDR_W-1:0] idx;
    logic [MEM_AW-1:0] widx;
    logic              addr_err;
    logic              complete;
    logic              proto_err;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    assign idx      = bus.paddr_i >> OFF_W;
    assign widx     = idx[MEM_AW-1:0];
    assign addr_err = (32'(idx) >= DEPTH_U);

`ifdef APB_MEM_SLAVE_RANDOM_WAIT_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 4'hE;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[1] ^ lfsr[3]};
        end
    end

    assign load_val = (lfsr > WAIT_4) ? WAIT_4 : lfsr;
`else
    assign load_val = WAIT_4;
`endif

    // The register only records IDLE/ACCESS; SETUP is the bus setup cycle itself,
    // decoded here so a transfer spans exactly WAIT_CYCLES + 2 cycles.
    always_comb begin
        phase = IDLE;
        if (state == ACCESS) begin
            phase = ACCESS;
        end else if (bus.psel_i && !bus.penable_i) begin
            phase = SETUP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (phase)
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= load_val;
                end
                ACCESS: begin
                    if (!bus.psel_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (bus.penable_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the responses so an in-flight enable cannot look like a protocol error.
    assign complete  = !reset && (state == ACCESS) && bus.psel_i && bus.penable_i && (cnt == 4'd0);
    assign proto_err = !reset && (state == IDLE) && bus.psel_i && bus.penable_i;
    assign wr_en     = complete && bus.pwrite_i && !addr_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BYTES; k++) begin
                if (bus.pstrb_i[k]) begin
                    mem[widx][8*k +: 8] <= bus.pwdata_i[8*k +: 8];
                end
            end
        end
    end

    assign bus.pready_o  = complete || proto_err;
    assign bus.pslverr_o = proto_err || (complete && addr_err);
    assign bus.prdata_o  = (complete && !bus.pwrite_i && !addr_err) ? mem[widx] : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: drivers queue expected responses,
// a negedge monitor pops and compares on every pready_o.
module tb_apb_mem_slave;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef APB_MEM_SLAVE_RANDOM_WAIT_EN
    localparam int WAIT = 3;
`else
    localparam int WAIT = 2;
`endif

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          waits;
        string       nm;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   acc;
    exp_t exp_q[$];
    logic [3:0] lfsr_m;

    apb_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_mem_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(16), .WAIT_CYCLES(WAIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 4'hE after reset, next = {l[2:0], l[1]^l[3]}.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 4'hE;
        else       lfsr_m <= {lfsr_m[2:0], lfsr_m[1] ^ lfsr_m[3]};
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    function automatic int model_wait();
`ifdef APB_MEM_SLAVE_RANDOM_WAIT_EN
        return (lfsr_m > 4'd3) ? 3 : int'(lfsr_m);
`else
        return WAIT;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            acc = 0;
        end else if (bus.pready_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pready", 64'(bus.pready_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.nm, "_pslverr"}, 64'(bus.pslverr_o), 64'(e.err));
                if (e.chk) check({e.nm, "_prdata"}, 64'(bus.prdata_o), 64'(e.data));
                check({e.nm, "_waits"}, 64'(acc), 64'(e.waits));
            end
            acc = 0;
        end else if (bus.psel_i && bus.penable_i) begin
            acc++;
        end else begin
            acc = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.psel_i    = 1'b0;
            bus.penable_i = 1'b0;
        end
    endtask

    task automatic setup(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = a;
        bus.pwdata_i  = d;
        bus.pstrb_i   = s;
    endtask

    task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic err, input logic chk, input logic [31:0] exp_d, input string nm);
        exp_t e;
        int   n;
        setup(wr, a, d, s);
        e.err = err; e.chk = chk; e.data = exp_d; e.waits = model_wait(); e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.pready_o) break;
            n++;
            if (n > 40) begin
                check({nm, "_timeout"}, 64'(n), 64'(e.waits));
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_t e;
        int   wtab [10] = '{3, 7, 0, 12, 15, 5, 9, 1, 14, 10};
        total = 0; passed = 0; acc = 0;
        reset = 1'b1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pwdata_i = '0; bus.pstrb_i = '0;
        repeat (3) @(negedge clk);
        check("reset_pready",  64'(bus.pready_o),  64'd0);
        check("reset_pslverr", 64'(bus.pslverr_o), 64'd0);
        check("reset_prdata",  64'(bus.prdata_o),  64'd0);
        @(posedge clk); #1 reset = 1'b0;

        xfer(1'b1, 10'h000, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 32'h0, "wr_000");
        xfer(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, "wr_010");
        xfer(1'b0, 10'h010, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, "rd_010");
        xfer(1'b0, 10'h012, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, "rd_012_lowbits");
        idle(2);

        xfer(1'b1, 10'h004, 32'h11223344, 4'hF,    1'b0, 1'b0, 32'h0, "wr_004_full");
        xfer(1'b1, 10'h004, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'h0, "wr_004_strb");
        xfer(1'b0, 10'h004, 32'h0,        4'h0,    1'b0, 1'b1, 32'h11BB33DD, "rd_004");
        xfer(1'b1, 10'h010, 32'h00000000, 4'h0,    1'b0, 1'b0, 32'h0, "wr_010_nostrb");
        xfer(1'b0, 10'h010, 32'h0,        4'h0,    1'b0, 1'b1, 32'hDEADBEEF, "rd_010_nostrb");

        xfer(1'b1, 10'h040, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0, "wr_040_oor");
        xfer(1'b0, 10'h040, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0, "rd_040_oor");
        xfer(1'b0, 10'h000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0BADF00D, "rd_000");
        xfer(1'b1, 10'h03C, 32'h600DCAFE, 4'hF, 1'b0, 1'b0, 32'h0, "wr_03c_last");
        xfer(1'b0, 10'h03C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h600DCAFE, "rd_03c_last");
        idle(2);

        // Enable without a setup cycle.
        @(posedge clk); #1;
        e.err = 1'b1; e.chk = 1'b1; e.data = 32'h0; e.waits = 0; e.nm = "proto";
        exp_q.push_back(e);
        bus.psel_i = 1'b1; bus.penable_i = 1'b1; bus.pwrite_i = 1'b1;
        bus.paddr_i = 10'h000; bus.pwdata_i = 32'hFFFFFFFF; bus.pstrb_i = 4'hF;
        idle(2);
        xfer(1'b0, 10'h000, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BADF00D, "rd_000_after_proto");
        idle(1);

`ifndef APB_MEM_SLAVE_RANDOM_WAIT_EN
        // Requester abandons a write after one access cycle.
        xfer(1'b1, 10'h008, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0, "wr_008");
        idle(1);
        setup(1'b1, 10'h008, 32'h12345678, 4'hF);
        @(posedge clk); #1 bus.penable_i = 1'b1;
        @(negedge clk);
        check("abort_acc1_pready", 64'(bus.pready_o), 64'd0);
        idle(1);
        @(negedge clk);
        check("abort_drop_pready", 64'(bus.pready_o), 64'd0);
        xfer(1'b0, 10'h008, 32'h0, 4'h0, 1'b0, 1'b1, 32'h55AA55AA, "rd_008_after_abort");

        // Reset lands in the second access cycle of a write.
        xfer(1'b1, 10'h00C, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, "wr_00c");
        setup(1'b1, 10'h00C, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1 bus.penable_i = 1'b1;
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("midrst_pready",  64'(bus.pready_o),  64'd0);
        check("midrst_pslverr", 64'(bus.pslverr_o), 64'd0);
        check("midrst_prdata",  64'(bus.prdata_o),  64'd0);
        idle(1);
        @(posedge clk); #1 reset = 1'b0;
        xfer(1'b0, 10'h00C, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D, "rd_00c_after_rst");
        xfer(1'b1, 10'h01C, 32'h0F1E2D3C, 4'hF, 1'b0, 1'b0, 32'h0, "wr_01c_after_rst");
        xfer(1'b0, 10'h01C, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0F1E2D3C, "rd_01c_after_rst");
`else
        for (int i = 0; i < 10; i++) begin
            xfer(1'b1, 10'(wtab[i] * 4), {8'hC0 + 8'(i), 8'h5A, 8'(wtab[i]), 8'hA5}, 4'hF,
                 1'b0, 1'b0, 32'h0, $sformatf("rnd_wr%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            xfer(1'b0, 10'(wtab[i] * 4), 32'h0, 4'h0,
                 1'b0, 1'b1, {8'hC0 + 8'(i), 8'h5A, 8'(wtab[i]), 8'hA5}, $sformatf("rnd_rd%0d", i));
        end
`endif
        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 completer with a word-addressed storage array, byte strobes, programmable or pseudo-random wait states and PSLVERR on out-of-range or mis-sequenced accesses. It replaces the fixed 16x32 request/ready memory wrapper as the standard bus endpoint for block-level register and scratch storage. It sits directly on an APB requester and runs from a single clock.

## Interface

Parameters:
- ADDR_W, 10, PADDR width in bits.
- DATA_W, 32, data width; must be 8, 16, 32 or 64.
- DEPTH, 16, number of DATA_W words; need not be a power of two; 1 <= DEPTH <= 2^(ADDR_W - log2(DATA_W/8)).
- WAIT_CYCLES, 2, wait states per access (0..15); upper bound in random mode.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- paddr_i  in  ADDR_W  byte address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  DATA_W  write data.
- pstrb_i  in  DATA_W/8  write byte strobes.
- prdata_o  out  DATA_W  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error; valid only with pready_o.

## Operation

- Word index idx = paddr_i >> log2(DATA_W/8); low address bits are ignored.
- Address error: idx >= DEPTH.
- FSM states: IDLE, SETUP, ACCESS; reset state IDLE.
  - IDLE/ACCESS-complete -> SETUP when psel_i & ~penable_i.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> ACCESS while wait counter != 0.
  - ACCESS, psel_i dropped before completion: abort -> IDLE; no write, no pready_o.
- Wait counter (4-bit): loaded in SETUP, decremented each ACCESS cycle while nonzero.
- Completion: ACCESS & psel_i & penable_i & counter == 0.
- On completion:
  - Write with no error: mem[idx] byte k <= pwdata_i byte k for each pstrb_i[k] = 1; other bytes unchanged; pstrb_i = 0 writes nothing.
  - Read with no error: prdata_o = mem[idx].
  - Address error: pslverr_o = 1, prdata_o = 0, no write.
- Protocol error: psel_i & penable_i while in IDLE (no SETUP). Response is pready_o = 1 and pslverr_o = 1 in that cycle, no write, prdata_o = 0; the FSM stays in IDLE.
- Outside a completing cycle: prdata_o = 0, pslverr_o = 0, pready_o = 0.
- Storage array has no reset. Reading an unwritten word returns X in simulation.

## Timing

- Reset values: pready_o = 0, pslverr_o = 0, prdata_o = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-transfer: the transfer is abandoned and outputs go to reset values immediately. The array keeps its contents.
- Fixed mode: pready_o is high in ACCESS cycle WAIT_CYCLES + 1; the transfer lasts WAIT_CYCLES + 2 cycles including SETUP.
- prdata_o, pready_o and pslverr_o are combinational from state, counter, paddr_i and the array; they are valid in the completing cycle only.
- A write is visible to a read whose SETUP is in the cycle after completion (back-to-back).
- Back-to-back transfers: SETUP may directly follow a completing ACCESS with no IDLE cycle.

## Configuration

- APB_MEM_SLAVE_RANDOM_WAIT_EN defined:
  - A 4-bit LFSR resets to 4'hE and advances every cycle: next = {l[2:0], l[1]^l[3]}.
  - SETUP loads the counter with min(lfsr, WAIT_CYCLES).
- Not defined: SETUP loads WAIT_CYCLES and no LFSR is instantiated.

## Test plan

- Fixed mode, defaults: write 0xDEADBEEF to paddr 0x010 with pstrb 4'hF, then read 0x010 -> pready_o on the 3rd ACCESS cycle each time; read returns 0xDEADBEEF, pslverr_o = 0.
- Byte strobes: write 0x11223344 to 0x004 with 4'hF, then 0xAABBCCDD with 4'b0101; read 0x004 -> 0x11BB33DD.
- Out of range: write to paddr 0x040 (idx 16), then read 0x040 -> pslverr_o = 1 with pready_o, prdata_o = 0; a read of idx 0 shows it unchanged.
- Protocol/abort: assert psel_i & penable_i from IDLE -> pready_o = pslverr_o = 1 that cycle. Separately, drop psel_i after 1 ACCESS cycle of a write to 0x008 -> no pready_o, and a later read of 0x008 shows the old data.
- Random mode with WAIT_CYCLES = 3: 10 writes then 10 reads to random in-range addresses -> every read matches its write, every wait count is in 0..3, and the wait sequence matches the LFSR model from 4'hE.
- Reset asserted in the 2nd ACCESS cycle of a write -> outputs 0 the same cycle, no write, and the next transfer completes normally.
